// File: rtl/pc_redirect_pkg.sv
// Shared types and defaults for the fetch-side PC sequencer.
// Default widths and reset PC mirror the core's constants header.
package pc_redirect_pkg;

  localparam int          XLEN_DEF         = 32;
  localparam int          THREAD_WIDTH_DEF = 2;
  localparam logic [31:0] RESET_PC_DEF     = 32'h0000_0000;
  localparam logic [31:0] STAT_MAX         = 32'hFFFF_FFFF;

  typedef enum logic {
    RUN     = 1'b0,
    WAIT_BR = 1'b1
  } thread_state_t;

  function automatic int num_threads(input int tw);
    return 1 << tw;
  endfunction

endpackage

// File: rtl/pc_redirect_rr_arbiter.sv
// Combinational round-robin pick among requesting threads.
// The search starts just after `last`; `last` itself is tried last.
module rr_arbiter
  import pc_redirect_pkg::*;
#(
  parameter int THREAD_WIDTH = THREAD_WIDTH_DEF,
  localparam int NUM_THREADS = num_threads(THREAD_WIDTH)
) (
  input  logic [NUM_THREADS-1:0]  req,
  input  logic [THREAD_WIDTH-1:0] last,
  output logic                    gnt_valid,
  output logic [THREAD_WIDTH-1:0] gnt_id
);

  logic [THREAD_WIDTH-1:0] idx;

  // Walk farthest-first so the closest requester after `last` wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    for (int i = NUM_THREADS; i >= 1; i--) begin
      idx = last + THREAD_WIDTH'(i);
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = idx;
      end
    end
  end

endmodule

// File: rtl/pc_redirect.sv
// Per-thread PC sequencer: round-robin fetch, park on control flow, redirect on resolution.
// Optional branch statistics counters: PC_REDIRECT_STATS_EN.
//   state   | meaning
//   RUN     | thread eligible for fetch
//   WAIT_BR | parked until its branch result is popped
module pc_redirect
  import pc_redirect_pkg::*;
#(
  parameter int               XLEN         = XLEN_DEF,
  parameter int               THREAD_WIDTH = THREAD_WIDTH_DEF,
  parameter logic [XLEN-1:0]  RESET_PC     = XLEN'(RESET_PC_DEF)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall_i,
  input  logic                    br_valid_i,
  input  logic                    br_empty_i,
  input  logic                    br_true_i,
  input  logic [THREAD_WIDTH-1:0] br_thread_id_i,
  input  logic [XLEN-1:0]         br_pc_n_i,
  output logic                    pc_ack_o,
  input  logic                    ctrl_valid_i,
  input  logic [THREAD_WIDTH-1:0] ctrl_thread_id_i,
  output logic                    fetch_valid_o,
  output logic [XLEN-1:0]         fetch_pc_o,
  output logic [THREAD_WIDTH-1:0] fetch_thread_id_o,
  output logic                    err_o
`ifdef PC_REDIRECT_STATS_EN
  ,
  output logic [31:0]             stat_taken_o,
  output logic [31:0]             stat_not_taken_o
`endif
);

  localparam int NUM_THREADS = num_threads(THREAD_WIDTH);

  logic [XLEN-1:0]         pc      [NUM_THREADS];
  thread_state_t           st      [NUM_THREADS];
  thread_state_t           st_next [NUM_THREADS];
  logic                    err_next;
  logic [THREAD_WIDTH-1:0] last;
  logic [NUM_THREADS-1:0]  req;
  logic                    gnt_valid;
  logic [THREAD_WIDTH-1:0] gnt_id;

  // Gated by rst so the FIFO is never popped while reset is held.
  assign pc_ack_o = rst & br_valid_i & ~br_empty_i & ~stall_i;

  always_comb begin
    req = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      req[t] = (st[t] == RUN) &&
               !(ctrl_valid_i && (ctrl_thread_id_i == THREAD_WIDTH'(t)));
    end
  end

  rr_arbiter #(
    .THREAD_WIDTH(THREAD_WIDTH)
  ) u_arb (
    .req      (req),
    .last     (last),
    .gnt_valid(gnt_valid),
    .gnt_id   (gnt_id)
  );

  // Ack is evaluated after park so a same-thread resolve wins over a bogus re-park.
  always_comb begin
    st_next  = st;
    err_next = err_o;
    if (!stall_i && ctrl_valid_i) begin
      if (st[ctrl_thread_id_i] == WAIT_BR) err_next = 1'b1;
      else                                 st_next[ctrl_thread_id_i] = WAIT_BR;
    end
    if (pc_ack_o) begin
      if (st[br_thread_id_i] == WAIT_BR) st_next[br_thread_id_i] = RUN;
      else                               err_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int t = 0; t < NUM_THREADS; t++) st[t] <= RUN;
      err_o <= 1'b0;
    end else begin
      st    <= st_next;
      err_o <= err_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int t = 0; t < NUM_THREADS; t++) pc[t] <= RESET_PC;
      last              <= THREAD_WIDTH'(NUM_THREADS - 1);
      fetch_valid_o     <= 1'b0;
      fetch_pc_o        <= '0;
      fetch_thread_id_o <= '0;
    end else if (!stall_i) begin
      fetch_valid_o <= gnt_valid;
      if (gnt_valid) begin
        fetch_pc_o        <= pc[gnt_id];
        fetch_thread_id_o <= gnt_id;
        pc[gnt_id]        <= pc[gnt_id] + XLEN'(4);
        last              <= gnt_id;
      end
      // A parked thread is never granted, so this cannot collide with the increment.
      if (pc_ack_o && (st[br_thread_id_i] == WAIT_BR)) begin
        pc[br_thread_id_i] <= br_pc_n_i;
      end
    end
  end

`ifdef PC_REDIRECT_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_taken_o     <= '0;
      stat_not_taken_o <= '0;
    end else if (pc_ack_o) begin
      if (br_true_i) begin
        if (stat_taken_o != STAT_MAX) stat_taken_o <= stat_taken_o + 32'd1;
      end else begin
        if (stat_not_taken_o != STAT_MAX) stat_not_taken_o <= stat_not_taken_o + 32'd1;
      end
    end
  end
`else
  logic unused_br_true;
  assign unused_br_true = br_true_i;
`endif

endmodule

// File: tb/tb_pc_redirect.sv
// Directed plus randomized bench for pc_redirect against a per-thread behavioural model.
module tb_pc_redirect;

  localparam int TW = 2;
  localparam int NT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall_i = 1'b0;
  logic          br_valid_i = 1'b0;
  logic          br_empty_i = 1'b1;
  logic          br_true_i = 1'b0;
  logic [TW-1:0] br_thread_id_i = '0;
  logic [31:0]   br_pc_n_i = '0;
  logic          pc_ack_o;
  logic          ctrl_valid_i = 1'b0;
  logic [TW-1:0] ctrl_thread_id_i = '0;
  logic          fetch_valid_o;
  logic [31:0]   fetch_pc_o;
  logic [TW-1:0] fetch_thread_id_o;
  logic          err_o;
`ifdef PC_REDIRECT_STATS_EN
  logic [31:0]   stat_taken_o;
  logic [31:0]   stat_not_taken_o;
`endif

  pc_redirect dut (
    .clk              (clk),
    .rst              (rst),
    .stall_i          (stall_i),
    .br_valid_i       (br_valid_i),
    .br_empty_i       (br_empty_i),
    .br_true_i        (br_true_i),
    .br_thread_id_i   (br_thread_id_i),
    .br_pc_n_i        (br_pc_n_i),
    .pc_ack_o         (pc_ack_o),
    .ctrl_valid_i     (ctrl_valid_i),
    .ctrl_thread_id_i (ctrl_thread_id_i),
    .fetch_valid_o    (fetch_valid_o),
    .fetch_pc_o       (fetch_pc_o),
    .fetch_thread_id_o(fetch_thread_id_o),
    .err_o            (err_o)
`ifdef PC_REDIRECT_STATS_EN
    ,
    .stat_taken_o     (stat_taken_o),
    .stat_not_taken_o (stat_not_taken_o)
`endif
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Behavioural model: one PC and a parked flag per thread.
  logic [31:0] m_pc [NT];
  bit          m_wait [NT];
  int          m_last;
  bit          m_fv;
  logic [31:0] m_fpc;
  int          m_ftid;
  bit          m_err;
  logic [31:0] m_taken;
  logic [31:0] m_ntaken;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic void model_reset();
    for (int t = 0; t < NT; t++) begin
      m_pc[t]   = 32'h0;
      m_wait[t] = 1'b0;
    end
    m_last = NT - 1; m_fv = 1'b0; m_fpc = 32'h0; m_ftid = 0; m_err = 1'b0;
    m_taken = 32'h0; m_ntaken = 32'h0;
  endfunction

  function automatic void model_step(input bit s, input bit bv, input bit be, input bit bt,
                                     input int btid, input logic [31:0] bpc,
                                     input bit cv, input int ctid);
    bit old_wait [NT];
    bit found;
    int sel;
    bit ack;
    if (s) return;
    ack = bv && !be;
    for (int t = 0; t < NT; t++) old_wait[t] = m_wait[t];
    found = 1'b0; sel = 0;
    for (int k = 1; k <= NT; k++) begin
      int t;
      t = (m_last + k) % NT;
      if (!found && !old_wait[t] && !(cv && ctid == t)) begin
        found = 1'b1; sel = t;
      end
    end
    m_fv = found;
    if (found) begin
      m_fpc = m_pc[sel]; m_ftid = sel; m_pc[sel] = m_pc[sel] + 32'd4; m_last = sel;
    end
    if (cv) begin
      if (old_wait[ctid]) m_err = 1'b1;
      else                m_wait[ctid] = 1'b1;
    end
    if (ack) begin
      if (old_wait[btid]) begin
        m_pc[btid] = bpc; m_wait[btid] = 1'b0;
      end else begin
        m_err = 1'b1;
      end
      if (bt) begin if (m_taken != 32'hFFFF_FFFF) m_taken++; end
      else    begin if (m_ntaken != 32'hFFFF_FFFF) m_ntaken++; end
    end
  endfunction

  // One clock: drive at edge+1, check ack combinationally, then check registered outputs.
  task automatic cyc(input bit s, input bit bv, input bit be, input bit bt, input int btid,
                     input logic [31:0] bpc, input bit cv, input int ctid);
    stall_i = s; br_valid_i = bv; br_empty_i = be; br_true_i = bt;
    br_thread_id_i = TW'(btid); br_pc_n_i = bpc;
    ctrl_valid_i = cv; ctrl_thread_id_i = TW'(ctid);
    #1;
    check("pc_ack", 64'(pc_ack_o), 64'(bv && !be && !s));
    model_step(s, bv, be, bt, btid, bpc, cv, ctid);
    @(posedge clk); #1;
    check("fetch_valid", 64'(fetch_valid_o), 64'(m_fv));
    check("fetch_tid", 64'(fetch_thread_id_o), 64'(m_ftid));
    check("fetch_pc", 64'(fetch_pc_o), 64'(m_fpc));
    check("err", 64'(err_o), 64'(m_err));
`ifdef PC_REDIRECT_STATS_EN
    check("stat_taken", 64'(stat_taken_o), 64'(m_taken));
    check("stat_not_taken", 64'(stat_not_taken_o), 64'(m_ntaken));
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 1, 0, 0, 32'h0, 0, 0);
  endtask

  // Asserts rst asynchronously with an ack-worthy FIFO head to prove the ack gate.
  task automatic do_reset();
    stall_i = 1'b0; br_valid_i = 1'b1; br_empty_i = 1'b0; ctrl_valid_i = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_pc_ack", 64'(pc_ack_o), 64'h0);
    check("rst_fetch_valid", 64'(fetch_valid_o), 64'h0);
    check("rst_fetch_pc", 64'(fetch_pc_o), 64'h0);
    check("rst_fetch_tid", 64'(fetch_thread_id_o), 64'h0);
    check("rst_err", 64'(err_o), 64'h0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check("rst_hold_valid", 64'(fetch_valid_o), 64'h0);
    br_valid_i = 1'b0; br_empty_i = 1'b1;
    rst = 1'b1;
  endtask

  initial begin
    int exp_tid [5];
    int exp_seq [4];
    logic [31:0] found_pc;
    logic [31:0] pcs [2];
    int n_found;
    bit all_wait;
    logic [31:0] held_pc;
    int bt_pat [5];

    exp_tid = '{0, 1, 2, 3, 0};
    exp_seq = '{2, 3, 0, 2};
    bt_pat  = '{1, 1, 0, 1, 0};

    #2;
    do_reset();

    // Plain round-robin after reset.
    for (int i = 0; i < 5; i++) begin
      idle(1);
      check("rr_tid", 64'(fetch_thread_id_o), 64'(exp_tid[i]));
      check("rr_pc", 64'(fetch_pc_o), (i == 4) ? 64'h4 : 64'h0);
    end

    // Park thread 1 while its PC 0x4 is on the fetch outputs.
    idle(1);
    check("t1_on_fetch", {32'(fetch_thread_id_o), fetch_pc_o}, {32'd1, 32'h4});
    cyc(0, 0, 1, 0, 0, 32'h0, 1, 1);
    check("skip_seq0", 64'(fetch_thread_id_o), 64'(exp_seq[0]));
    for (int i = 1; i < 4; i++) begin
      idle(1);
      check("skip_seq", 64'(fetch_thread_id_o), 64'(exp_seq[i]));
    end
    cyc(0, 1, 0, 1, 1, 32'h100, 0, 0);
    found_pc = 32'hDEAD_BEEF;
    for (int i = 0; i < 8; i++) begin
      idle(1);
      if (fetch_valid_o && fetch_thread_id_o == 2'd1) begin
        found_pc = fetch_pc_o;
        break;
      end
    end
    check("redirect_t1", 64'(found_pc), 64'h100);

    // Park every thread, then release only thread 2.
    all_wait = 1'b0;
    for (int i = 0; i < 20 && !all_wait; i++) begin
      if (m_fv && !m_wait[m_ftid]) cyc(0, 0, 1, 0, 0, 32'h0, 1, m_ftid);
      else                         idle(1);
      all_wait = m_wait[0] && m_wait[1] && m_wait[2] && m_wait[3];
    end
    check("park_all_done", 64'(all_wait), 64'h1);
    idle(1);
    check("all_parked_valid", 64'(fetch_valid_o), 64'h0);
    cyc(0, 1, 0, 0, 2, 32'h40, 0, 0);
    idle(1);
    check("t2_redirect", {31'h0, fetch_valid_o, 30'(fetch_thread_id_o), 2'b00, fetch_pc_o},
          {31'h0, 1'b1, 30'd2, 2'b00, 32'h40});

    // FIFO handshake corners and stall freeze.
    cyc(0, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 0);
    cyc(0, 1, 1, 0, 0, 32'hFFFF_FFFC, 0, 0);
    held_pc = fetch_pc_o;
    cyc(1, 1, 0, 1, 0, 32'hFFFF_FFFC, 0, 0);
    cyc(1, 1, 0, 1, 0, 32'hFFFF_FFFC, 0, 0);
    check("stall_hold_pc", 64'(fetch_pc_o), 64'(held_pc));
    cyc(0, 1, 0, 1, 0, 32'hFFFF_FFFC, 0, 0);

    // Thread 0 now sits at the top of the address space and must wrap.
    n_found = 0;
    pcs[0] = 32'h1; pcs[1] = 32'h1;
    for (int i = 0; i < 12 && n_found < 2; i++) begin
      idle(1);
      if (fetch_valid_o && fetch_thread_id_o == 2'd0) begin
        pcs[n_found] = fetch_pc_o;
        n_found++;
      end
    end
    check("wrap_first", 64'(pcs[0]), 64'hFFFF_FFFC);
    check("wrap_second", 64'(pcs[1]), 64'h0);

    // Ack for a running thread is an error, and it sticks.
    cyc(0, 1, 0, 0, 2, 32'h999, 0, 0);
    idle(3);
    check("err_sticky", 64'(err_o), 64'h1);

    // Mid-operation reset while threads 1 and 3 are parked.
    check("pre_reset_parked", 64'(m_wait[1] && m_wait[3]), 64'h1);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check("post_rst", {32'(fetch_thread_id_o), fetch_pc_o}, {32'(i), 32'h0});
    end

`ifdef PC_REDIRECT_STATS_EN
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, bt_pat[i][0], i % NT, 32'h0, 0, 0);
    check("stats_taken3", 64'(stat_taken_o), 64'd3);
    check("stats_nt2", 64'(stat_not_taken_o), 64'd2);
    do_reset();
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      bit s, bv, be, bt, cv;
      int btid, ctid, w, st0;
      logic [31:0] bpc;
      s = ($urandom % 8) == 0;
      cv = 0; ctid = 0;
      if (m_fv && !m_wait[m_ftid] && ($urandom % 3) == 0) begin
        cv = 1; ctid = m_ftid;
      end else if (($urandom % 60) == 0) begin
        cv = 1; ctid = $urandom % NT;
      end
      w = -1; st0 = $urandom % NT;
      for (int k = 0; k < NT; k++) begin
        if (w < 0 && m_wait[(st0 + k) % NT] && !(cv && ctid == (st0 + k) % NT))
          w = (st0 + k) % NT;
      end
      if (w >= 0) begin
        bv = ($urandom % 2) == 1; be = ($urandom % 5) == 0; btid = w;
      end else begin
        bv = ($urandom % 40) == 0; be = 1'b0; btid = $urandom % NT;
      end
      bt  = ($urandom % 2) == 1;
      bpc = $urandom & 32'hFFFF_FFFC;
      cyc(s, bv, be, bt, btid, bpc, cv, ctid);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
